ped_request_ctrl: RTL

- Upstream conditioning stage for the traffic-light controller.
- Turns a raw, bouncy, active-low pedestrian push-button into a clean, latched pedestrian request, `ped_req`.
- The state stage consumes `ped_req` and returns a one-cycle `ack` when it begins serving the pedestrian phase.
- After each serviced request, a hold-off window blocks new requests so pedestrians cannot starve the road phases.
- Runs entirely on the board clock `clk50M`.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/ped_request_ctrl_if.sv | 32 +++
 rtl/ped_request_ctrl_btn_debounce.sv | 50 +++++
 rtl/ped_request_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and board timing constants for the traffic-light controller.
package traffic_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;   // 20 ms
    localparam int DEF_HOLDOFF_CYCLES  = CLK_HZ * 10;   // 10 s

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } ped_state_t;

endpackage

// File: rtl/ped_request_ctrl_if.sv
// Pedestrian request link between the button conditioning stage and the state stage.
interface ped_request_ctrl_if;
    import traffic_pkg::*;

    // ped_req is a level held high until the state stage pulses ack for one cycle;
    // ack is only honoured while ped_req is high, and the request drops on that edge.
    logic       btn_n;
    logic       ack;
    logic       ped_req;
    logic       btn_level;
    logic       press_ignored;
    logic [1:0] ped_state;

    modport master (
        output btn_n,
        output ack,
        input  ped_req,
        input  btn_level,
        input  press_ignored,
        input  ped_state
    );

    modport slave (
        input  btn_n,
        input  ack,
        output ped_req,
        output btn_level,
        output press_ignored,
        output ped_state
    );

endinterface

// File: rtl/ped_request_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for an active-low key; emits a
// clean pressed level and a one-cycle press pulse.
module btn_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [DW-1:0] r_cnt;
    logic          r_level_d;
    logic          w_level;

    // r_stable holds the active-low debounced level, so pressed is its inverse.
    assign w_level = ~r_stable;
    assign o_level = w_level;
    assign o_press = w_level & ~r_level_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_stable  <= 1'b1;
            r_cnt     <= '0;
            r_level_d <= 1'b0;
        end else begin
            r_s1      <= i_btn_n;
            r_s2      <= r_s1;
            r_level_d <= w_level;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/ped_request_ctrl.sv
// Latches a debounced pedestrian press into ped_req until acked, then blocks new
// requests for a hold-off window.
module ped_request_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
    parameter int CW              = $clog2(HOLDOFF_CYCLES + 1),
    parameter int DW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk50M,
    input  logic               Reset,
    ped_request_ctrl_if.slave  bus
);

    // A zero hold-off still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (CW > 0) ? CW : 1;

    ped_state_t       r_state;
    ped_state_t       w_state_next;
    logic [CNT_W-1:0] r_cool;
    logic [CNT_W-1:0] w_cool_next;
    logic             r_ped_req;
    logic             r_press_ignored;
    logic             w_ignore;
    logic             w_level;
    logic             w_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DW              (DW)
    ) u_btn_debounce (
        .i_clk   (clk50M),
        .i_rst   (Reset),
        .i_btn_n (bus.btn_n),
        .o_level (w_level),
        .o_press (w_press)
    );

    assign bus.ped_req       = r_ped_req;
    assign bus.btn_level     = w_level;
    assign bus.press_ignored = r_press_ignored;
    assign bus.ped_state     = r_state;

    always_ff @(posedge clk50M) begin
        if (Reset) begin
            r_state         <= IDLE;
            r_cool          <= '0;
            r_ped_req       <= 1'b0;
            r_press_ignored <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cool          <= w_cool_next;
            r_ped_req       <= (w_state_next == PENDING);
            r_press_ignored <= w_ignore;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cool_next  = r_cool;
        w_ignore     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                // ack beats a coincident press, which is reported as discarded.
                if (bus.ack) begin
                    w_ignore = w_press;
                    if (HOLDOFF_CYCLES == 0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = COOLDOWN;
                        w_cool_next  = CNT_W'(HOLDOFF_CYCLES);
                    end
                end
            end
            COOLDOWN: begin
                w_ignore = w_press;
                if (r_cool <= CNT_W'(1)) begin
                    w_state_next = IDLE;
                    w_cool_next  = '0;
                end else begin
                    w_cool_next = r_cool - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cool_next  = '0;
            end
        endcase
    end

endmodule
